// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer
// with an internal 32x32 register file and one shared memory port.
// Supported: add, sub, and, or, nor, jr, addi, ori, lw, sw, beq, bne, j, jal.
// Optional feature macro: PORT_IO_EN. When it is defined, the words at
// PORT_IN_ADDR and PORT_OUT_ADDR are serviced inside the core. These accesses
// make no memory request and spend a single cycle in MEM.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter logic [31:0] PORT_IN_ADDR  = 32'h1001_0024,
   parameter logic [31:0] PORT_OUT_ADDR = 32'h1001_0028
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic [31:0] ALUResultOut,
   output logic        trap
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_NOR   = 6'h27;

   state_t      state;
   state_t      state_next;

   logic [31:0] pc;
   logic [31:0] ir;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [31:0] imm_ext;
   logic [31:0] br_target;
   logic [31:0] mdr;
   logic [31:0] regs [0:31];

   // Instruction fields, always taken from the latched IR
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm16;
   logic [25:0] imm26;

   assign opcode = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign funct  = ir[5:0];
   assign imm16  = ir[15:0];
   assign imm26  = ir[25:0];

   // Instruction classification
   logic is_alu_r;
   logic is_jr;
   logic is_addi;
   logic is_ori;
   logic is_lw;
   logic is_sw;
   logic is_beq;
   logic is_bne;
   logic is_j;
   logic is_jal;
   logic legal;

   assign is_alu_r = (opcode == OP_RTYPE) &&
                     ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_NOR));
   assign is_jr    = (opcode == OP_RTYPE) && (funct == FN_JR);
   assign is_addi  = (opcode == OP_ADDI);
   assign is_ori   = (opcode == OP_ORI);
   assign is_lw    = (opcode == OP_LW);
   assign is_sw    = (opcode == OP_SW);
   assign is_beq   = (opcode == OP_BEQ);
   assign is_bne   = (opcode == OP_BNE);
   assign is_j     = (opcode == OP_J);
   assign is_jal   = (opcode == OP_JAL);
   assign legal    = is_alu_r | is_jr | is_addi | is_ori | is_lw | is_sw |
                     is_beq | is_bne | is_j | is_jal;

   // Register file read ports; $0 reads as zero regardless of storage
   logic [31:0] rf_a;
   logic [31:0] rf_b;
   logic [31:0] sext16;

   assign rf_a   = (rs == 5'd0) ? 32'h0 : regs[rs];
   assign rf_b   = (rt == 5'd0) ? 32'h0 : regs[rt];
   assign sext16 = {{16{imm16[15]}}, imm16};

   // The low two address bits are dropped so every access is word aligned
   logic [31:0] mem_word_addr;
   assign mem_word_addr = {ALUResultOut[31:2], 2'b00};

   logic port_in_hit;
   logic port_out_hit;
   logic port_hit;
   logic unused_bits;

`ifdef PORT_IO_EN
   assign port_in_hit  = is_lw && (mem_word_addr == {PORT_IN_ADDR[31:2], 2'b00});
   assign port_out_hit = is_sw && (mem_word_addr == {PORT_OUT_ADDR[31:2], 2'b00});
   assign unused_bits  = ^{ir[10:6]};
`else
   assign port_in_hit  = 1'b0;
   assign port_out_hit = 1'b0;
   assign unused_bits  = ^{ir[10:6], PortIn, PORT_IN_ADDR, PORT_OUT_ADDR};
`endif

   assign port_hit = port_in_hit | port_out_hit;

   // ALU: R-type ops on A/B, ori with a zero-extended immediate, and
   // otherwise A + sign-extended immediate (addi and the lw/sw address)
   logic [31:0] alu_y;

   always_comb begin
      alu_y = a_reg + imm_ext;
      if (is_alu_r) begin
         case (funct)
            FN_SUB:  alu_y = a_reg - b_reg;
            FN_AND:  alu_y = a_reg & b_reg;
            FN_OR:   alu_y = a_reg | b_reg;
            FN_NOR:  alu_y = ~(a_reg | b_reg);
            default: alu_y = a_reg + b_reg;
         endcase
      end else if (is_ori) begin
         alu_y = a_reg | {16'h0000, imm16};
      end
   end

   // Next-state logic for the instruction sequencer
   always_comb begin
      state_next = state;
      case (state)
         FETCH: begin
            if (mem_ready) begin
               state_next = DECODE;
            end
         end
         DECODE: begin
            state_next = legal ? EXEC : TRAP;
         end
         EXEC: begin
            if (is_lw || is_sw) begin
               state_next = MEM;
            end else if (is_alu_r || is_addi || is_ori) begin
               state_next = WB;
            end else begin
               state_next = FETCH;
            end
         end
         MEM: begin
            if (port_hit || mem_ready) begin
               state_next = is_lw ? WB : FETCH;
            end
         end
         WB:      state_next = FETCH;
         TRAP:    state_next = TRAP;
         default: state_next = FETCH;
      endcase
   end

   // Memory port drive; held at zero while reset is asserted so a pending
   // request is dropped at the reset edge
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      if (reset) begin
         case (state)
            FETCH: begin
               mem_req  = 1'b1;
               mem_addr = {pc[31:2], 2'b00};
            end
            MEM: begin
               if (!port_hit) begin
                  mem_req   = 1'b1;
                  mem_we    = is_sw;
                  mem_addr  = mem_word_addr;
                  mem_wdata = is_sw ? b_reg : 32'h0;
               end
            end
            default: ;
         endcase
      end
   end

   // Sequencer state, PC, instruction/operand latches and the trap flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= FETCH;
         pc           <= RESET_PC;
         ir           <= 32'h0;
         a_reg        <= 32'h0;
         b_reg        <= 32'h0;
         imm_ext      <= 32'h0;
         br_target    <= 32'h0;
         mdr          <= 32'h0;
         ALUResultOut <= 32'h0;
         trap         <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            FETCH: begin
               if (mem_ready) begin
                  ir <= mem_rdata;
                  pc <= pc + 32'd4;
               end
            end
            DECODE: begin
               a_reg     <= rf_a;
               b_reg     <= rf_b;
               imm_ext   <= sext16;
               br_target <= pc + {sext16[29:0], 2'b00};
               if (!legal) begin
                  trap <= 1'b1;
               end
            end
            EXEC: begin
               ALUResultOut <= alu_y;
               if ((is_beq && (a_reg == b_reg)) || (is_bne && (a_reg != b_reg))) begin
                  pc <= br_target;
               end else if (is_j || is_jal) begin
                  pc <= {pc[31:28], imm26, 2'b00};
               end else if (is_jr) begin
                  pc <= a_reg;
               end
            end
            MEM: begin
               if (port_in_hit) begin
                  mdr <= {24'h0, PortIn};
               end else if (mem_ready && is_lw) begin
                  mdr <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   // Write port: jal links $31 in EXEC together with its PC update, all
   // other results land in WB; $0 is never written
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = rt;
      rf_wdata = ALUResultOut;
      if ((state == EXEC) && is_jal) begin
         rf_we    = 1'b1;
         rf_waddr = 5'd31;
         rf_wdata = pc;
      end else if (state == WB) begin
         rf_we = 1'b1;
         if (is_alu_r) begin
            rf_waddr = rd;
         end
         if (is_lw) begin
            rf_wdata = mdr;
         end
      end
   end

   // Register file storage
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'h0;
         end
      end else if (rf_we && (rf_waddr != 5'd0)) begin
         regs[rf_waddr] <= rf_wdata;
      end
   end

`ifdef PORT_IO_EN
   // Output port register, loaded by a store to PORT_OUT_ADDR
   always_ff @(posedge clk) begin
      if (!reset) begin
         PortOut <= 32'h0;
      end else if ((state == MEM) && port_out_hit) begin
         PortOut <= b_reg;
      end
   end
`else
   assign PortOut = 32'h0;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small programs in a bench-side
// memory with a programmable wait count; results observed on the memory
// port (fetch addresses/cycles, store data) and on the core outputs.
module tb_mips_multicycle_core;

   localparam logic [31:0] PIN  = 32'h1001_0024;
   localparam logic [31:0] POUT = 32'h1001_0028;

   logic        clk;
   logic        reset;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [7:0]  PortIn;
   logic [31:0] PortOut;
   logic [31:0] ALUResultOut;
   logic        trap;

   mips_multicycle_core dut (
      .clk          (clk),
      .reset        (reset),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .PortIn       (PortIn),
      .PortOut      (PortOut),
      .ALUResultOut (ALUResultOut),
      .trap         (trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: ready after wait_n cycles of a held request
   logic [31:0] mem [0:255];
   int          wait_n;
   int          cnt;

   assign mem_ready = mem_req && (cnt == wait_n);
   assign mem_rdata = mem_req ? mem[mem_addr[9:2]] : 32'h0;

   always @(posedge clk) begin
      cnt <= (mem_req && !mem_ready) ? cnt + 1 : 0;
   end

   int n_vec;
   int n_fail;

   logic [31:0] rd_addr [0:7];
   int          rd_cyc  [0:7];
   logic [31:0] st_addr [0:3];
   logic [31:0] st_data [0:3];
   int          st_cyc  [0:3];
   int          n_rd;
   int          n_st;
   int          port_touch;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [15:0] a;
      logic [15:0] b;
      logic [4:0]  sreg;
      logic [31:0] exp;
   } vec_t;

   vec_t vq[$];

   function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
      return {6'h00, rs, rt, rd, 5'h00, f};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
      return {op, tgt[27:2]};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_trap", {31'h0, trap}, 32'h0);
      check("rst_alu_out", ALUResultOut, 32'h0);
      check("rst_port_out", PortOut, 32'h0);
      reset = 1'b1;
      #1;
      check("first_fetch_req", {31'h0, mem_req}, 32'h1);
      check("first_fetch_addr", mem_addr, 32'h0);
   endtask

   // Runs a fixed number of cycles, logging reads and stores with the
   // cycle (1-based) in which they complete
   task automatic run(input int ncyc);
      n_rd = 0;
      n_st = 0;
      port_touch = 0;
      for (int i = 0; i < 4; i++) begin
         st_addr[i] = 32'h0; st_data[i] = 32'h0; st_cyc[i] = 0;
      end
      for (int i = 0; i < 8; i++) begin
         rd_addr[i] = 32'h0; rd_cyc[i] = 0;
      end
      for (int c = 1; c <= ncyc; c++) begin
         if (mem_req && mem_ready) begin
            if (mem_we) begin
               if (n_st < 4) begin
                  st_addr[n_st] = mem_addr; st_data[n_st] = mem_wdata; st_cyc[n_st] = c;
                  n_st++;
               end
            end else if (n_rd < 8) begin
               rd_addr[n_rd] = mem_addr; rd_cyc[n_rd] = c;
               n_rd++;
            end
         end
         if (mem_req && ((mem_addr == PIN) || (mem_addr == POUT))) port_touch++;
         step();
      end
   endtask

   logic [31:0] spin;
   logic [31:0] exp_ra [0:4];
   int          exp_rc [0:4];
   logic        found;

   initial begin
      n_vec  = 0;
      n_fail = 0;
      reset  = 1'b0;
      PortIn = 8'hA5;
      wait_n = 0;
      spin   = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);

      vq.push_back('{"add",      enc_r(6'h20, 5'd3, 5'd1, 5'd2), 16'd5,    16'd7,    5'd3, 32'd12});
      vq.push_back('{"sub",      enc_r(6'h22, 5'd3, 5'd1, 5'd2), 16'd5,    16'd7,    5'd3, 32'hFFFF_FFFE});
      vq.push_back('{"and",      enc_r(6'h24, 5'd3, 5'd1, 5'd2), 16'h0F0F, 16'h00FF, 5'd3, 32'h0000_000F});
      vq.push_back('{"or",       enc_r(6'h25, 5'd3, 5'd1, 5'd2), 16'h0F00, 16'h00F0, 5'd3, 32'h0000_0FF0});
      vq.push_back('{"nor",      enc_r(6'h27, 5'd3, 5'd1, 5'd2), 16'h0F0F, 16'h00F0, 5'd3, 32'hFFFF_F000});
      vq.push_back('{"add_wrap", enc_r(6'h20, 5'd3, 5'd1, 5'd2), 16'hFFFF, 16'h0001, 5'd3, 32'h0000_0000});
      vq.push_back('{"sub_wrap", enc_r(6'h22, 5'd3, 5'd1, 5'd2), 16'h8000, 16'h7FFF, 5'd3, 32'hFFFF_0001});
      vq.push_back('{"ori_zext", enc_i(6'h0D, 5'd3, 5'd1, 16'h8001), 16'h0010, 16'd0, 5'd3, 32'h0000_8011});
      vq.push_back('{"addi_neg", enc_i(6'h08, 5'd3, 5'd1, 16'hFFFE), 16'd5, 16'd0,    5'd3, 32'd3});
      vq.push_back('{"write_r0", enc_r(6'h20, 5'd0, 5'd1, 5'd2), 16'd5,    16'd7,    5'd0, 32'd0});
      vq.push_back('{"ori_sext", enc_i(6'h0D, 5'd3, 5'd1, 16'h0000), 16'hFFFF, 16'd0, 5'd3, 32'hFFFF_FFFF});

      // ALU table: addi $1,a ; addi $2,b ; op ; sw sreg,0x100 ; spin
      foreach (vq[k]) begin
         clear_mem();
         mem[0] = enc_i(6'h08, 5'd1, 5'd0, vq[k].a);
         mem[1] = enc_i(6'h08, 5'd2, 5'd0, vq[k].b);
         mem[2] = vq[k].instr;
         mem[3] = enc_i(6'h2B, vq[k].sreg, 5'd0, 16'h0100);
         mem[4] = spin;
         do_reset();
         run(20);
         check({vq[k].name, "_data"}, st_data[0], vq[k].exp);
         check({vq[k].name, "_addr"}, st_addr[0], 32'h100);
         check({vq[k].name, "_cycle"}, st_cyc[0], 16);
      end

      // addi then add: $2 = 10 after 8 cycles
      clear_mem();
      mem[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
      mem[1] = enc_r(6'h20, 5'd2, 5'd1, 5'd1);
      mem[2] = enc_i(6'h2B, 5'd2, 5'd0, 16'h0100);
      mem[3] = spin;
      do_reset();
      run(8);
      check("seq_alu_out", ALUResultOut, 32'd10);
      run(8);
      check("seq_r2", st_data[0], 32'd10);
      check("seq_st_cyc", st_cyc[0], 4);

      // Branches: bne not taken at 0, filler at 4, beq self-loop at 8
      clear_mem();
      mem[0] = enc_i(6'h05, 5'd0, 5'd0, 16'h0004);
      mem[1] = enc_i(6'h08, 5'd1, 5'd0, 16'd7);
      mem[2] = spin;
      do_reset();
      run(15);
      exp_ra = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8};
      exp_rc = '{1, 4, 8, 11, 14};
      check("br_nreads", n_rd, 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("br_fetch_addr%0d", i), rd_addr[i], exp_ra[i]);
         check($sformatf("br_fetch_cyc%0d", i), rd_cyc[i], exp_rc[i]);
      end

      // j 0x10 ; 0x10: jal 0x40 ; 0x40: jr $31 ; 0x14: sw $31,0x100
      clear_mem();
      mem[0]  = enc_j(6'h02, 32'h10);
      mem[4]  = enc_j(6'h03, 32'h40);
      mem[16] = enc_r(6'h08, 5'd0, 5'd31, 5'd0);
      mem[5]  = enc_i(6'h2B, 5'd31, 5'd0, 16'h0100);
      mem[6]  = spin;
      do_reset();
      run(16);
      exp_ra = '{32'h0, 32'h10, 32'h40, 32'h14, 32'h14};
      exp_rc = '{1, 4, 7, 10, 0};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("jal_fetch_addr%0d", i), rd_addr[i], exp_ra[i]);
         check($sformatf("jal_fetch_cyc%0d", i), rd_cyc[i], exp_rc[i]);
      end
      check("jal_r31", st_data[0], 32'h14);
      check("jal_st_cyc", st_cyc[0], 13);

      // lw with 3 wait states: request held 4 cycles at a stable address
      wait_n = 3;
      clear_mem();
      mem[0]  = enc_j(6'h02, 32'h20);
      mem[1]  = 32'hDEAD_BEEF;
      mem[8]  = enc_i(6'h23, 5'd3, 5'd0, 16'h0004);
      mem[9]  = enc_i(6'h2B, 5'd3, 5'd0, 16'h0100);
      mem[10] = spin;
      do_reset();
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (mem_req && !mem_we && (mem_addr == 32'h4)) found = 1'b1;
         else step();
      end
      check("lw_req_seen", {31'h0, found}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("lw_hold_req%0d", k), {31'h0, mem_req}, 32'h1);
         check($sformatf("lw_hold_addr%0d", k), mem_addr, 32'h4);
         check($sformatf("lw_hold_rdy%0d", k), {31'h0, mem_ready}, (k == 3) ? 32'h1 : 32'h0);
         step();
      end
      run(20);
      check("lw_r3", st_data[0], 32'hDEAD_BEEF);

      // Reset during a waiting fetch drops the request at that edge
      do_reset();
      run(2);
      check("midrst_req_before", {31'h0, mem_req}, 32'h1);
      reset = 1'b0;
      step();
      check("midrst_req_drop", {31'h0, mem_req}, 32'h0);
      reset = 1'b1;
      #1;
      check("midrst_refetch_req", {31'h0, mem_req}, 32'h1);
      check("midrst_refetch_addr", mem_addr, 32'h0);
      wait_n = 0;

      // Port accesses: lw $5,0x80 ; lw $6,0x24($5) ; sw $6,0x28($5) ; sw $6,0x100
      clear_mem();
      mem[0]  = enc_i(6'h23, 5'd5, 5'd0, 16'h0080);
      mem[1]  = enc_i(6'h23, 5'd6, 5'd5, 16'h0024);
      mem[2]  = enc_i(6'h2B, 5'd6, 5'd5, 16'h0028);
      mem[3]  = enc_i(6'h2B, 5'd6, 5'd0, 16'h0100);
      mem[4]  = spin;
      mem[9]  = 32'h1122_3344;
      mem[32] = 32'h1001_0000;
      do_reset();
      run(20);
`ifdef PORT_IO_EN
      check("port_out", PortOut, 32'h0000_00A5);
      check("port_no_req", port_touch, 0);
      check("port_st_data", st_data[0], 32'h0000_00A5);
      check("port_st_addr", st_addr[0], 32'h100);
      check("port_st_cyc", st_cyc[0], 18);
`else
      check("port_out_tied", PortOut, 32'h0);
      check("port_mem_st_addr", st_addr[0], POUT);
      check("port_mem_st_data", st_data[0], 32'h1122_3344);
      check("port_mem_st_cyc", st_cyc[0], 14);
      check("port_st2_cyc", st_cyc[1], 18);
`endif

      // Illegal opcode: trap is sticky, no requests, cleared by reset
      clear_mem();
      mem[0] = 32'hFC00_0000;
      do_reset();
      run(6);
      check("trap_set", {31'h0, trap}, 32'h1);
      check("trap_nreads", n_rd, 1);
      check("trap_nstores", n_st, 0);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("trap_req_low%0d", k), {31'h0, mem_req}, 32'h0);
         step();
      end
      reset = 1'b0;
      step();
      check("trap_clear", {31'h0, trap}, 32'h0);
      reset = 1'b1;
      #1;
      check("trap_refetch_req", {31'h0, mem_req}, 32'h1);
      check("trap_refetch_addr", mem_addr, 32'h0);

      // Illegal funct inside R-type
      mem[0] = enc_r(6'h3F, 5'd1, 5'd0, 5'd0);
      do_reset();
      run(5);
      check("trap_funct", {31'h0, trap}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
